// File: rtl/frame_buffer_swap_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frame_buffer_swap_if                                   |
// | Description : Writer, reader and status signals of the multi-buffered|
// |               frame store, grouped for one port connection.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface frame_buffer_swap_if #(
  parameter int H_BITS = 8,
  parameter int V_BITS = 8,
  parameter int PIX_W  = 8,
  parameter int DROP_W = 8
);
  // Renderer side
  logic              wr_en;
  logic [H_BITS-1:0] wr_x;
  logic [V_BITS-1:0] wr_y;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ready;
  logic              frame_done;

  // Video timing side
  logic              rd_en;
  logic [H_BITS-1:0] rd_x;
  logic [V_BITS-1:0] rd_y;
  logic [PIX_W-1:0]  rd_data;
  logic              vblank_start;

  // Status
  logic              swap;
  logic [1:0]        disp_buf;
  logic [DROP_W-1:0] frames_dropped;

  // Environment view: drives strobes and coordinates, observes status
  modport master (
    output wr_en, wr_x, wr_y, wr_data, frame_done,
    output rd_en, rd_x, rd_y, vblank_start,
    input  wr_ready, rd_data, swap, disp_buf, frames_dropped
  );

  // Frame store view
  modport slave (
    input  wr_en, wr_x, wr_y, wr_data, frame_done,
    input  rd_en, rd_x, rd_y, vblank_start,
    output wr_ready, rd_data, swap, disp_buf, frames_dropped
  );
endinterface
`default_nettype wire

// File: rtl/frame_buffer_swap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frame_buffer_swap                                      |
// | Description : Double/triple-buffered pixel frame store between the   |
// |               renderer and the video timing generator. Buffer roles  |
// |               rotate on frame_done / vblank_start pulses.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module frame_buffer_swap #(
  parameter int H_BITS   = 8,
  parameter int V_BITS   = 8,
  parameter int PIX_W    = 8,
  parameter int NUM_BUFS = 2,
  parameter int DROP_W   = 8
) (
  input  wire logic           clk_sys,
  input  wire logic           reset_n,
  frame_buffer_swap_if.slave  bus
);

  // Only double and triple buffering are meaningful
  generate
    if ((NUM_BUFS != 2) && (NUM_BUFS != 3)) begin : g_bad_num_bufs
      $error("frame_buffer_swap: NUM_BUFS must be 2 or 3");
    end
  endgenerate

  // One buffer is 2**(H_BITS+V_BITS) pixels; the buffer index sits on top
  localparam int c_DEPTH = NUM_BUFS << (H_BITS + V_BITS);
  localparam int c_IDX_W = $clog2(c_DEPTH);

  typedef enum logic [0:0] {
    ST_WRITING = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Registered control state
  state_t            r_state;
  logic [1:0]        r_wr_buf;
  logic [1:0]        r_disp_buf;
  logic [1:0]        r_ready_buf;
  logic              r_ready_valid;
  logic              r_swap;
  logic [DROP_W-1:0] r_drops;
  logic [PIX_W-1:0]  r_rd_data;

  // Frame storage, no reset
  logic [PIX_W-1:0]  r_mem [c_DEPTH];

  // Next-state values
  state_t            w_state_nxt;
  logic [1:0]        w_wr_buf_nxt;
  logic [1:0]        w_disp_buf_nxt;
  logic [1:0]        w_ready_buf_nxt;
  logic              w_ready_valid_nxt;
  logic              w_swap_nxt;
  logic              w_drop_evt;
  logic [DROP_W-1:0] w_drops_nxt;

  logic              w_wr_ready;
  logic              w_wr_accept;
  logic [c_IDX_W-1:0] w_wr_addr;
  logic [c_IDX_W-1:0] w_rd_addr;

  // The triple-buffered writer always has a free buffer to draw into;
  // the double-buffered writer stalls while its frame waits for vblank.
  assign w_wr_ready  = (NUM_BUFS == 3) ? 1'b1 : (r_state == ST_WRITING);
  assign w_wr_accept = bus.wr_en & w_wr_ready;

  // Address is plain concatenation {buf, y, x}. The cast only drops the
  // upper buffer-index bit in double mode, where it is always zero.
  assign w_wr_addr = c_IDX_W'({r_wr_buf,   bus.wr_y, bus.wr_x});
  assign w_rd_addr = c_IDX_W'({r_disp_buf, bus.rd_y, bus.rd_x});

  // Next buffer roles, swap strobe and drop accounting
  always_comb begin
    w_state_nxt       = r_state;
    w_wr_buf_nxt      = r_wr_buf;
    w_disp_buf_nxt    = r_disp_buf;
    w_ready_buf_nxt   = r_ready_buf;
    w_ready_valid_nxt = r_ready_valid;
    w_swap_nxt        = 1'b0;
    w_drop_evt        = 1'b0;
    w_drops_nxt       = r_drops;

    if (NUM_BUFS == 2) begin
      case (r_state)
        ST_WRITING: begin
          if (bus.frame_done && bus.vblank_start) begin
            // Frame finished exactly at vblank: flip without stalling
            w_wr_buf_nxt   = r_disp_buf;
            w_disp_buf_nxt = r_wr_buf;
            w_swap_nxt     = 1'b1;
          end else if (bus.frame_done) begin
            w_state_nxt = ST_PENDING;
          end
        end
        ST_PENDING: begin
          // Extra frame_done pulses here are ignored
          if (bus.vblank_start) begin
            w_wr_buf_nxt   = r_disp_buf;
            w_disp_buf_nxt = r_wr_buf;
            w_swap_nxt     = 1'b1;
            w_state_nxt    = ST_WRITING;
          end
        end
        default: begin
          w_state_nxt = ST_WRITING;
        end
      endcase
    end else begin
      if (bus.frame_done && bus.vblank_start) begin
        // Completed frame goes straight to display; any parked frame is lost
        w_drop_evt        = r_ready_valid;
        w_disp_buf_nxt    = r_wr_buf;
        w_wr_buf_nxt      = r_disp_buf;
        w_ready_valid_nxt = 1'b0;
        w_swap_nxt        = 1'b1;
      end else if (bus.frame_done) begin
        // Park the completed frame, writer takes over the old parked buffer
        w_drop_evt        = r_ready_valid;
        w_ready_buf_nxt   = r_wr_buf;
        w_wr_buf_nxt      = r_ready_buf;
        w_ready_valid_nxt = 1'b1;
      end else if (bus.vblank_start && r_ready_valid) begin
        w_disp_buf_nxt    = r_ready_buf;
        w_ready_buf_nxt   = r_disp_buf;
        w_ready_valid_nxt = 1'b0;
        w_swap_nxt        = 1'b1;
      end
    end

    if (w_drop_evt && (r_drops != {DROP_W{1'b1}})) begin
      w_drops_nxt = r_drops + DROP_W'(1);
    end
  end

  // Control state register; reset mid-frame restores the initial roles
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_WRITING;
      r_wr_buf      <= 2'd0;
      r_disp_buf    <= 2'd1;
      r_ready_buf   <= 2'd2;
      r_ready_valid <= 1'b0;
      r_swap        <= 1'b0;
      r_drops       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_buf      <= w_wr_buf_nxt;
      r_disp_buf    <= w_disp_buf_nxt;
      r_ready_buf   <= w_ready_buf_nxt;
      r_ready_valid <= w_ready_valid_nxt;
      r_swap        <= w_swap_nxt;
      r_drops       <= w_drops_nxt;
    end
  end

  // RAM write port into the current write buffer
  always_ff @(posedge clk_sys) begin
    if (w_wr_accept) begin
      r_mem[w_wr_addr] <= bus.wr_data;
    end
  end

  // RAM read port from the display buffer as it was before this edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (bus.rd_en) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign bus.wr_ready       = w_wr_ready;
  assign bus.rd_data        = r_rd_data;
  assign bus.swap           = r_swap;
  assign bus.disp_buf       = r_disp_buf;
  assign bus.frames_dropped = r_drops;

  // The three buffer roles must never alias
  a_roles_distinct: assert property (@(posedge clk_sys) disable iff (!reset_n)
    (r_wr_buf != r_disp_buf) && (r_wr_buf != r_ready_buf) && (r_disp_buf != r_ready_buf));

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_swap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_frame_buffer_swap                                   |
// | Description : Bench for frame_buffer_swap; one double- and one      |
// |               triple-buffered instance checked against a frame model.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_frame_buffer_swap;
  localparam int HB     = 3;
  localparam int VB     = 3;
  localparam int PW     = 8;
  localparam int DW     = 2;
  localparam int NPIX   = 1 << (HB + VB);
  localparam int DROP_MAX = (1 << DW) - 1;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  frame_buffer_swap_if #(.H_BITS(HB), .V_BITS(VB), .PIX_W(PW), .DROP_W(DW)) if_d ();
  frame_buffer_swap_if #(.H_BITS(HB), .V_BITS(VB), .PIX_W(PW), .DROP_W(DW)) if_t ();

  frame_buffer_swap #(.H_BITS(HB), .V_BITS(VB), .PIX_W(PW), .NUM_BUFS(2), .DROP_W(DW)) u_dbl (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (if_d)
  );

  frame_buffer_swap #(.H_BITS(HB), .V_BITS(VB), .PIX_W(PW), .NUM_BUFS(3), .DROP_W(DW)) u_tri (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (if_t)
  );

  // Reference model: k=0 double, k=1 triple
  logic [7:0] m_mem [2][3][NPIX];
  bit         m_val [2][3][NPIX];
  int         m_wb [2], m_db [2], m_rb [2], m_drop [2];
  bit         m_rv [2], m_pend [2], m_swap [2], m_rdv [2];
  logic [7:0] m_rd [2];
  int         sw_cnt [2];

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_wb[k] = 0; m_db[k] = 1; m_rb[k] = 2;
    m_rv[k] = 0; m_pend[k] = 0; m_swap[k] = 0; m_drop[k] = 0;
    m_rd[k] = 8'h00; m_rdv[k] = 1;
  endtask

  task automatic model_edge(input int k, input bit we, input int wx, input int wy,
                            input logic [7:0] wd, input bit fd, input bit re,
                            input int rx, input int ry, input bit vb);
    int t;
    bit ready;
    ready = (k == 1) || !m_pend[k];
    if (re) begin
      m_rd[k]  = m_mem[k][m_db[k]][ry * (1 << HB) + rx];
      m_rdv[k] = m_val[k][m_db[k]][ry * (1 << HB) + rx];
    end
    if (we && ready) begin
      m_mem[k][m_wb[k]][wy * (1 << HB) + wx] = wd;
      m_val[k][m_wb[k]][wy * (1 << HB) + wx] = 1;
    end
    m_swap[k] = 0;
    if (k == 0) begin
      if (m_pend[k]) begin
        if (vb) begin
          t = m_db[k]; m_db[k] = m_wb[k]; m_wb[k] = t;
          m_pend[k] = 0; m_swap[k] = 1;
        end
      end else if (fd && vb) begin
        t = m_db[k]; m_db[k] = m_wb[k]; m_wb[k] = t;
        m_swap[k] = 1;
      end else if (fd) begin
        m_pend[k] = 1;
      end
    end else begin
      if (fd && vb) begin
        if (m_rv[k] && m_drop[k] < DROP_MAX) m_drop[k]++;
        t = m_db[k]; m_db[k] = m_wb[k]; m_wb[k] = t;
        m_rv[k] = 0; m_swap[k] = 1;
      end else if (fd) begin
        if (m_rv[k] && m_drop[k] < DROP_MAX) m_drop[k]++;
        t = m_rb[k]; m_rb[k] = m_wb[k]; m_wb[k] = t;
        m_rv[k] = 1;
      end else if (vb && m_rv[k]) begin
        t = m_db[k]; m_db[k] = m_rb[k]; m_rb[k] = t;
        m_rv[k] = 0; m_swap[k] = 1;
      end
    end
  endtask

  task automatic compare_all();
    check_val("dbl.wr_ready", if_d.wr_ready, m_pend[0] ? 0 : 1);
    check_val("dbl.swap", if_d.swap, m_swap[0]);
    check_val("dbl.disp_buf", if_d.disp_buf, m_db[0]);
    check_val("dbl.dropped", if_d.frames_dropped, m_drop[0]);
    if (m_rdv[0]) check_val("dbl.rd_data", if_d.rd_data, m_rd[0]);
    check_val("dbl.distinct", (u_dbl.r_wr_buf != u_dbl.r_disp_buf) &&
              (u_dbl.r_wr_buf != u_dbl.r_ready_buf) && (u_dbl.r_disp_buf != u_dbl.r_ready_buf), 1);
    check_val("tri.wr_ready", if_t.wr_ready, 1);
    check_val("tri.swap", if_t.swap, m_swap[1]);
    check_val("tri.disp_buf", if_t.disp_buf, m_db[1]);
    check_val("tri.dropped", if_t.frames_dropped, m_drop[1]);
    if (m_rdv[1]) check_val("tri.rd_data", if_t.rd_data, m_rd[1]);
    check_val("tri.distinct", (u_tri.r_wr_buf != u_tri.r_disp_buf) &&
              (u_tri.r_wr_buf != u_tri.r_ready_buf) && (u_tri.r_disp_buf != u_tri.r_ready_buf), 1);
  endtask

  // One clock: model follows the sampled inputs, outputs checked at negedge
  task automatic tick();
    @(posedge clk_sys);
    if (!reset_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0, if_d.wr_en, int'(if_d.wr_x), int'(if_d.wr_y), if_d.wr_data, if_d.frame_done,
                 if_d.rd_en, int'(if_d.rd_x), int'(if_d.rd_y), if_d.vblank_start);
      model_edge(1, if_t.wr_en, int'(if_t.wr_x), int'(if_t.wr_y), if_t.wr_data, if_t.frame_done,
                 if_t.rd_en, int'(if_t.rd_x), int'(if_t.rd_y), if_t.vblank_start);
    end
    @(negedge clk_sys);
    if (if_d.swap) sw_cnt[0]++;
    if (if_t.swap) sw_cnt[1]++;
    compare_all();
  endtask

  task automatic idle_all();
    if_d.wr_en = 0; if_d.wr_x = '0; if_d.wr_y = '0; if_d.wr_data = '0; if_d.frame_done = 0;
    if_d.rd_en = 0; if_d.rd_x = '0; if_d.rd_y = '0; if_d.vblank_start = 0;
    if_t.wr_en = 0; if_t.wr_x = '0; if_t.wr_y = '0; if_t.wr_data = '0; if_t.frame_done = 0;
    if_t.rd_en = 0; if_t.rd_x = '0; if_t.rd_y = '0; if_t.vblank_start = 0;
  endtask

  task automatic wr_pix(input int k, input int x, input int y, input logic [7:0] d);
    if (k == 0) begin
      if_d.wr_en = 1; if_d.wr_x = HB'(x); if_d.wr_y = VB'(y); if_d.wr_data = d;
    end else begin
      if_t.wr_en = 1; if_t.wr_x = HB'(x); if_t.wr_y = VB'(y); if_t.wr_data = d;
    end
  endtask

  task automatic rd_pix(input int k, input int x, input int y);
    if (k == 0) begin
      if_d.rd_en = 1; if_d.rd_x = HB'(x); if_d.rd_y = VB'(y);
    end else begin
      if_t.rd_en = 1; if_t.rd_x = HB'(x); if_t.rd_y = VB'(y);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 3; b++)
        for (int a = 0; a < NPIX; a++) begin
          m_mem[k][b][a] = 8'h00;
          m_val[k][b][a] = 0;
        end
    sw_cnt[0] = 0; sw_cnt[1] = 0;
    idle_all();
    reset_n = 0;
    model_reset(0);
    model_reset(1);
    @(negedge clk_sys);
    compare_all();
    tick();
    reset_n = 1;
    tick();

    // Frame done and vblank together: immediate flip, 1 -> 0
    if_d.frame_done = 1; if_d.vblank_start = 1;
    if_t.frame_done = 1; if_t.vblank_start = 1;
    tick();
    check_val("t3.dbl_swap", if_d.swap, 1);
    check_val("t3.dbl_ready", if_d.wr_ready, 1);
    check_val("t3.dbl_disp", if_d.disp_buf, 0);
    check_val("t3.tri_disp", if_t.disp_buf, 0);
    idle_all();
    tick();

    // Basic write / frame_done / vblank / read
    sw_cnt[0] = 0; sw_cnt[1] = 0;
    wr_pix(0, 5, 7, 8'hA5); wr_pix(1, 5, 7, 8'hA5);
    tick();
    idle_all();
    if_d.frame_done = 1; if_t.frame_done = 1;
    tick();
    idle_all();
    tick();
    if_d.vblank_start = 1; if_t.vblank_start = 1;
    tick();
    idle_all();
    rd_pix(0, 5, 7); rd_pix(1, 5, 7);
    tick();
    idle_all();
    check_val("t1.dbl_rd", if_d.rd_data, 8'hA5);
    check_val("t1.tri_rd", if_t.rd_data, 8'hA5);
    check_val("t1.dbl_swaps", sw_cnt[0], 1);
    check_val("t1.tri_swaps", sw_cnt[1], 1);

    // Double mode stall: write during PENDING is discarded
    wr_pix(0, 1, 1, 8'h11);
    tick();
    idle_all();
    if_d.frame_done = 1;
    tick();
    idle_all();
    check_val("t2.stall", if_d.wr_ready, 0);
    wr_pix(0, 1, 1, 8'h3C);
    tick();
    idle_all();
    check_val("t2.stall_hold", if_d.wr_ready, 0);
    if_d.vblank_start = 1;
    tick();
    idle_all();
    check_val("t2.resume", if_d.wr_ready, 1);
    rd_pix(0, 1, 1);
    tick();
    idle_all();
    check_val("t2.rd", if_d.rd_data, 8'h11);
    check_val("t2.discard", (if_d.rd_data == 8'h3C), 0);
    if_d.vblank_start = 1;
    tick();
    idle_all();
    check_val("t2.vb_noswap", if_d.swap, 0);

    // Triple mode: three frames without vblank, two dropped
    for (int i = 0; i < 3; i++) begin
      wr_pix(1, 2, 3, 8'(8'h40 + i));
      tick();
      idle_all();
      if_t.frame_done = 1;
      tick();
      idle_all();
    end
    check_val("t4.dropped", if_t.frames_dropped, 2);
    check_val("t4.ready", if_t.wr_ready, 1);
    if_t.vblank_start = 1;
    tick();
    idle_all();
    rd_pix(1, 2, 3);
    tick();
    idle_all();
    check_val("t4.third_frame", if_t.rd_data, 8'h42);
    for (int i = 0; i < 3; i++) begin
      if_t.frame_done = 1;
      tick();
      idle_all();
    end
    check_val("t4.saturate", if_t.frames_dropped, DROP_MAX);

    // Triple mode: reset between frame_done and vblank
    if_t.frame_done = 1;
    tick();
    idle_all();
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    check_val("t5.idx", {u_tri.r_wr_buf, u_tri.r_disp_buf, u_tri.r_ready_buf}, 6'b00_01_10);
    check_val("t5.dropped", if_t.frames_dropped, 0);
    if_t.vblank_start = 1;
    tick();
    idle_all();
    check_val("t5.noswap", if_t.swap, 0);
    check_val("t5.disp", if_t.disp_buf, 1);

    // Randomised traffic on both instances
    for (int n = 0; n < 2000; n++) begin
      if_d.wr_en = 1'($urandom_range(1, 0));
      if_d.wr_x = HB'($urandom_range(NPIX - 1, 0)); if_d.wr_y = VB'($urandom);
      if_d.wr_data = 8'($urandom);
      if_d.frame_done = ($urandom_range(7, 0) == 0);
      if_d.vblank_start = ($urandom_range(9, 0) == 0);
      if_d.rd_en = 1'($urandom_range(1, 0));
      if_d.rd_x = HB'($urandom); if_d.rd_y = VB'($urandom);
      if_t.wr_en = 1'($urandom_range(1, 0));
      if_t.wr_x = HB'($urandom); if_t.wr_y = VB'($urandom);
      if_t.wr_data = 8'($urandom);
      if_t.frame_done = ($urandom_range(5, 0) == 0);
      if_t.vblank_start = ($urandom_range(9, 0) == 0);
      if_t.rd_en = 1'($urandom_range(1, 0));
      if_t.rd_x = HB'($urandom); if_t.rd_y = VB'($urandom);
      reset_n = ($urandom_range(499, 0) != 0);
      tick();
    end
    reset_n = 1;
    idle_all();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
